// File: rtl/main_mem_ctrl_pkg.sv
// Shared widths and FSM encodings for the block-granular
// main-memory responder behind the cache memory port.
package main_mem_ctrl_pkg;

  localparam int PA_WIDTH  = 32;
  localparam int BLK_SIZE  = 64;
  localparam int MEM_WIDTH = BLK_SIZE * 8;
  localparam int BO_WIDTH  = $clog2(BLK_SIZE);

  typedef enum logic [2:0] {
    MEM_IDLE    = 3'd0,
    MEM_RD_WAIT = 3'd1,
    MEM_RD_RESP = 3'd2,
    MEM_WR_WAIT = 3'd3,
    MEM_WR_RESP = 3'd4
  } mem_state_e;

endpackage

// File: rtl/main_mem_ctrl_array.sv
// Single-port synchronous block RAM with a registered read port
// whose output register is the responder's read-data bus.
module mem_array #(
  parameter int WIDTH      = main_mem_ctrl_pkg::MEM_WIDTH,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // reset clears only the output register, never the contents
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency block read/write responder: one request at a time,
// write-back served before refill when both are raised together.
module main_mem_ctrl #(
  parameter int PA_WIDTH   = main_mem_ctrl_pkg::PA_WIDTH,
  parameter int MEM_WIDTH  = main_mem_ctrl_pkg::MEM_WIDTH,
  parameter int BO_WIDTH   = main_mem_ctrl_pkg::BO_WIDTH,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_ready,
  input  logic                 mem_rd_req,
  input  logic [PA_WIDTH-1:0]  mem_rd_addr,
  output logic [MEM_WIDTH-1:0] mem_rd_blk,
  output logic                 mem_rd_valid,
  input  logic                 mem_wr_en,
  input  logic [PA_WIDTH-1:0]  mem_wr_addr,
  input  logic [MEM_WIDTH-1:0] mem_wr_blk,
  output logic                 mem_wr_done
);
  import main_mem_ctrl_pkg::*;

  localparam int IW = DEPTH_LOG2;
  localparam int HI = BO_WIDTH + DEPTH_LOG2;
  localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LATENCY - 1);

  mem_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW-1:0]  idx_q;
  logic [MEM_WIDTH-1:0] wblk_q;
  logic acc_wr, acc_rd;
  logic arr_we, arr_re;

  logic unused_addr;
  assign unused_addr = ^{mem_rd_addr[PA_WIDTH-1:HI],
                         mem_rd_addr[BO_WIDTH-1:0],
                         mem_wr_addr[PA_WIDTH-1:HI],
                         mem_wr_addr[BO_WIDTH-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (mem_wr_en) begin
          acc_wr  = 1'b1;
          state_d = MEM_WR_WAIT;
          cnt_d   = WR_CNT;
        end else if (mem_rd_req) begin
          acc_rd  = 1'b1;
          state_d = MEM_RD_WAIT;
          cnt_d   = RD_CNT;
        end
      end
      MEM_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_RD_RESP;
          arr_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_WR_RESP;
          arr_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RD_RESP: state_d = MEM_IDLE;
      MEM_WR_RESP: state_d = MEM_IDLE;
      default:     state_d = MEM_IDLE;
    endcase
    // an aborted write must never reach the array
    if (rst) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wblk_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc_wr) begin
        idx_q  <= mem_wr_addr[BO_WIDTH +: IW];
        wblk_q <= mem_wr_blk;
      end else if (acc_rd) begin
        idx_q <= mem_rd_addr[BO_WIDTH +: IW];
      end
    end
  end

  assign mem_ready    = (state_q == MEM_IDLE);
  assign mem_rd_valid = (state_q == MEM_RD_RESP);
  assign mem_wr_done  = (state_q == MEM_WR_RESP);

  mem_array #(
    .WIDTH      (MEM_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (wblk_q),
    .rdata (mem_rd_blk)
  );

endmodule
